alu_exec_unit: RTL

Execute-stage ALU driven directly by the ALU control decoder's 3-bit ALU op code and A-source select. It computes add/sub/or/and in one cycle. Shifts run on an iterative serial shifter, one bit position per cycle. It uses a valid/ready handshake on both sides, so the issue logic stalls while a shift is in progress.

---
 rtl/alu_exec_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with single-cycle logic/arith ops and serial shifter
module alu_exec_unit #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic             alu_src_a,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic [SHW-1:0]     cnt;
    logic [1:0]         sop;
    logic               sign_q;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   res_c;
    logic               ovf_c;
    logic [SHW-1:0]     k;
    logic               is_shift;
    logic [WIDTH-1:0]   shift_c;

    // Single-cycle result, overflow and shift-amount selection from the live inputs
    always_comb begin
        sum      = rs_data + rt_data;
        diff     = rs_data - rt_data;
        k        = alu_src_a ? shamt : rs_data[SHW-1:0];
        is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
        res_c    = '0;
        ovf_c    = 1'b0;
        case (alu_op)
            OP_ADD: begin
                res_c = sum;
                ovf_c = (rs_data[WIDTH-1] == rt_data[WIDTH-1]) &&
                        (sum[WIDTH-1] != rs_data[WIDTH-1]);
            end
            OP_SUB: begin
                res_c = diff;
                ovf_c = (rs_data[WIDTH-1] != rt_data[WIDTH-1]) &&
                        (diff[WIDTH-1] != rs_data[WIDTH-1]);
            end
            OP_OR:  res_c = rs_data | rt_data;
            OP_AND: res_c = rs_data & rt_data;
            // Zero-distance shifts pass the operand straight through
            OP_SLL, OP_SRL, OP_SRA: res_c = rt_data;
            default: res_c = '0;
        endcase
    end

    // One-position step of the serial shifter; sra refills with the latched sign
    always_comb begin
        shift_c = sreg;
        case (sop)
            2'b00:   shift_c = {sreg[WIDTH-2:0], 1'b0};
            2'b01:   shift_c = {1'b0, sreg[WIDTH-1:1]};
            2'b10:   shift_c = {sign_q, sreg[WIDTH-1:1]};
            default: shift_c = sreg;
        endcase
    end

    // Control FSM with registered handshake outputs and result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            sreg      <= '0;
            cnt       <= '0;
            sop       <= 2'b00;
            sign_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (is_shift && (k != '0)) begin
                            sreg   <= rt_data;
                            cnt    <= k;
                            sop    <= alu_op[1:0];
                            sign_q <= rt_data[WIDTH-1];
                            state  <= SHIFT;
                        end else begin
                            result    <= res_c;
                            zero      <= (res_c == '0);
                            overflow  <= ovf_c;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    sreg <= shift_c;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        result    <= shift_c;
                        zero      <= (shift_c == '0);
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
